// File: rtl/mem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_loader_pkg
// Brief    : Shared state encoding, port word width and helpers for mem_loader.
// Revision : 1.0 - initial release
// ============================================================================
package mem_loader_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_I  = 3'd1,
    S_LOAD_D  = 3'd2,
    S_RUN     = 3'd3,
    S_RD_REQ  = 3'd4,
    S_RD_WAIT = 3'd5,
    S_RD_OUT  = 3'd6,
    S_DONE    = 3'd7
  } state_t;

  // nz = {rd, run, dmem, imem} non-zero flags; earlier phases already done are passed as 0
  function automatic state_t first_phase(input logic [3:0] nz);
    if (nz[0])      return S_LOAD_I;
    else if (nz[1]) return S_LOAD_D;
    else if (nz[2]) return S_RUN;
    else if (nz[3]) return S_RD_REQ;
    else            return S_DONE;
  endfunction

  function automatic logic [WORD_W-1:0] word_addr(input logic [WORD_W-1:0] idx,
                                                   input int step);
    return idx * WORD_W'(step);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_loader_run_timer.sv
`default_nettype none
// ============================================================================
// Module   : run_timer
// Brief    : Loadable down-counter that times the processor run phase.
// Revision : 1.0 - initial release
// ============================================================================
module run_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero,
  output logic             last
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (dec && (r_count != '0)) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign zero = (r_count == '0);
  assign last = (r_count == CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : mem_loader
// Brief    : Streams words into instruction/data memories, runs the core for a
//            fixed cycle count, then streams data memory contents back out.
// Revision : 1.0 - initial release
// ============================================================================
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int ADDR_STEP = 4,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              start,
  input  logic [9:0]        imem_len,
  input  logic [9:0]        dmem_len,
  input  logic [9:0]        rd_len,
  input  logic [CNT_W-1:0]  run_cycles,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [WORD_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              enable,
  output logic [WORD_W-1:0] addr_ext,
  output logic              wen_ext,
  output logic              ren_ext,
  output logic [WORD_W-1:0] wdata_ext,
  output logic [WORD_W-1:0] addr_ext_2,
  output logic              wen_ext_2,
  output logic              ren_ext_2,
  output logic [WORD_W-1:0] wdata_ext_2,
  input  logic [WORD_W-1:0] rdata_ext_2
);

  localparam int LEN_W = 10;

  state_t            r_state;
  state_t            w_next;
  logic [LEN_W-1:0]  r_idx;
  logic [LEN_W-1:0]  r_imem_len;
  logic [LEN_W-1:0]  r_dmem_len;
  logic [LEN_W-1:0]  r_rd_len;
  logic [WORD_W-1:0] r_out_data;
  logic [WORD_W-1:0] w_addr;
  logic              w_accept;
  logic              w_wr_i;
  logic              w_wr_d;
  logic              w_idx_clr;
  logic              w_idx_inc;
  logic              w_tmr_zero;
  logic              w_tmr_last;

  assign w_accept = ((r_state == S_IDLE) || (r_state == S_DONE)) && start;
  assign w_wr_i   = (r_state == S_LOAD_I) && in_valid;
  assign w_wr_d   = (r_state == S_LOAD_D) && in_valid;
  assign w_addr   = word_addr(WORD_W'(r_idx), ADDR_STEP);

  // Timer is loaded at start so its zero flag doubles as the "run phase present" flag
  run_timer #(
    .CNT_W (CNT_W)
  ) u_run_timer (
    .clk      (clk),
    .arst_n   (arst_n),
    .load     (w_accept),
    .load_val (run_cycles),
    .dec      (r_state == S_RUN),
    .zero     (w_tmr_zero),
    .last     (w_tmr_last)
  );

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_next = first_phase({rd_len != '0, run_cycles != '0,
                                dmem_len != '0, imem_len != '0});
        end
      end
      S_LOAD_I: begin
        if (in_valid && (r_idx == r_imem_len - LEN_W'(1))) begin
          w_next = first_phase({r_rd_len != '0, !w_tmr_zero, r_dmem_len != '0, 1'b0});
        end
      end
      S_LOAD_D: begin
        if (in_valid && (r_idx == r_dmem_len - LEN_W'(1))) begin
          w_next = first_phase({r_rd_len != '0, !w_tmr_zero, 2'b00});
        end
      end
      S_RUN: begin
        if (w_tmr_last) begin
          w_next = first_phase({r_rd_len != '0, 3'b000});
        end
      end
      S_RD_REQ:  w_next = S_RD_WAIT;
      S_RD_WAIT: w_next = S_RD_OUT;
      S_RD_OUT: begin
        if (out_ready) begin
          w_next = (r_idx == r_rd_len - LEN_W'(1)) ? S_DONE : S_RD_REQ;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready    = 1'b0;
    wen_ext     = 1'b0;
    ren_ext     = 1'b0;
    addr_ext    = '0;
    wdata_ext   = '0;
    wen_ext_2   = 1'b0;
    ren_ext_2   = 1'b0;
    addr_ext_2  = '0;
    wdata_ext_2 = '0;
    enable      = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    case (r_state)
      S_IDLE: busy = 1'b0;
      S_DONE: begin
        busy = 1'b0;
        done = 1'b1;
      end
      S_LOAD_I: begin
        in_ready = 1'b1;
        if (w_wr_i) begin
          wen_ext   = 1'b1;
          addr_ext  = w_addr;
          wdata_ext = in_data;
        end
      end
      S_LOAD_D: begin
        in_ready = 1'b1;
        if (w_wr_d) begin
          wen_ext_2   = 1'b1;
          addr_ext_2  = w_addr;
          wdata_ext_2 = in_data;
        end
      end
      S_RUN: enable = 1'b1;
      S_RD_REQ: begin
        ren_ext_2  = 1'b1;
        addr_ext_2 = w_addr;
      end
      S_RD_OUT: out_valid = 1'b1;
      default: ;
    endcase
  end

  // The read index survives the RD_REQ/RD_WAIT/RD_OUT loop; every other state change starts a new phase
  assign w_idx_clr = ((w_next != r_state) &&
                      (r_state inside {S_IDLE, S_DONE, S_LOAD_I, S_LOAD_D, S_RUN})) ||
                     ((r_state == S_RD_OUT) && (w_next == S_DONE));
  assign w_idx_inc = w_wr_i || w_wr_d || ((r_state == S_RD_OUT) && out_ready);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_idx      <= '0;
      r_imem_len <= '0;
      r_dmem_len <= '0;
      r_rd_len   <= '0;
      r_out_data <= '0;
    end else begin
      if (w_accept) begin
        r_imem_len <= imem_len;
        r_dmem_len <= dmem_len;
        r_rd_len   <= rd_len;
      end
      if (w_idx_clr) begin
        r_idx <= '0;
      end else if (w_idx_inc) begin
        r_idx <= r_idx + LEN_W'(1);
      end
      if (r_state == S_RD_WAIT) begin
        r_out_data <= rdata_ext_2;
      end
    end
  end

  assign out_data = r_out_data;

endmodule
`default_nettype wire
